btb_write_scheduler: RTL and testbench

- Owns the single BTB write port and schedules all writes to it.
- Runs the invalidation sweep after reset and after a flush request.
- Each cycle, takes up to REQ_NUM taken-branch update requests from the integer pipes. One is written directly; the rest are buffered in an internal FIFO and drained one write per cycle.
- Tells the fetch side when BTB reads must be blocked.

---
 rtl/btb_write_scheduler_if.sv | 33 +++
 rtl/btb_write_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_btb_write_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/btb_write_scheduler_if.sv
// BTB write scheduler bus: pipe update requests and flush in, BTB write port and status out.
interface btb_write_scheduler_if #(
  parameter int unsigned REQ_NUM     = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned INDEX_WIDTH = 9,
  parameter int unsigned ENTRY_WIDTH = 40
) ();

  logic [REQ_NUM-1:0]             reqValid;
  logic [REQ_NUM*INDEX_WIDTH-1:0] reqIndex;
  logic [REQ_NUM*ENTRY_WIDTH-1:0] reqEntry;
  logic                           flushReq;

  logic                           btbWE;
  logic [INDEX_WIDTH-1:0]         btbWA;
  logic [ENTRY_WIDTH-1:0]         btbWV;
  logic                           busy;
  logic [$clog2(QUEUE_DEPTH):0]   queueCount;
  logic [15:0]                    dropCount;

  // Requester / observer side.
  modport master (
    output reqValid, reqIndex, reqEntry, flushReq,
    input  btbWE, btbWA, btbWV, busy, queueCount, dropCount
  );

  // Scheduler side.
  modport slave (
    input  reqValid, reqIndex, reqEntry, flushReq,
    output btbWE, btbWA, btbWV, busy, queueCount, dropCount
  );

endinterface

// File: rtl/btb_write_scheduler.sv
// Owns the single BTB write port: invalidation sweeps after reset/flush, then direct writes of
// taken-branch updates with overflow lanes buffered in a small FIFO and drained one per cycle.
module btb_write_scheduler #(
  parameter int unsigned REQ_NUM     = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned INDEX_WIDTH = 9,
  parameter int unsigned ENTRY_WIDTH = 40
) (
  input logic                clk,
  input logic                rst_n,
  btb_write_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REC_W = INDEX_WIDTH + ENTRY_WIDTH;

  typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

  state_e                 r_state, w_state_d;
  logic [INDEX_WIDTH-1:0] r_sweep_idx, w_sweep_idx_d;
  logic [PTR_W-1:0]       r_head, w_head_d;
  logic [PTR_W-1:0]       r_tail, w_tail_d;
  logic [CNT_W-1:0]       r_count, w_count_d;
  logic [15:0]            r_drop, w_drop_d;
  logic [REC_W-1:0]       r_mem [QUEUE_DEPTH];

  logic [REQ_NUM-1:0]     w_keep;
  logic [REQ_NUM-1:0]     w_push_en;
  logic [PTR_W-1:0]       w_push_ptr [REQ_NUM];
  logic                   w_we;
  logic [INDEX_WIDTH-1:0] w_wa;
  logic [ENTRY_WIDTH-1:0] w_wv;
  logic [REC_W-1:0]       w_head_rec;

  assign w_head_rec = r_mem[r_head];

  // A lane survives unless a younger (higher) valid lane targets the same index.
  always_comb begin
    w_keep = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      w_keep[i] = bus.reqValid[i];
      for (int unsigned j = i + 1; j < REQ_NUM; j++) begin
        if (bus.reqValid[j] &&
            (bus.reqIndex[j*INDEX_WIDTH +: INDEX_WIDTH] ==
             bus.reqIndex[i*INDEX_WIDTH +: INDEX_WIDTH])) begin
          w_keep[i] = 1'b0;
        end
      end
    end
  end

  // Next-state, FIFO bookkeeping and write-port selection.
  always_comb begin : next_state
    logic               pop;
    logic               found;
    logic [REQ_NUM-1:0] direct;
    logic [PTR_W-1:0]   tail;
    logic [16:0]        drop_sum;
    int unsigned        free_slots;
    int unsigned        pushed;
    int unsigned        drops;

    w_state_d     = r_state;
    w_sweep_idx_d = r_sweep_idx;
    w_head_d      = r_head;
    w_tail_d      = r_tail;
    w_count_d     = r_count;
    w_drop_d      = r_drop;
    w_push_en     = '0;
    w_push_ptr    = '{default: '0};
    w_we          = 1'b0;
    w_wa          = '0;
    w_wv          = '0;
    pop           = 1'b0;
    found         = 1'b0;
    direct        = '0;
    tail          = r_tail;
    drop_sum      = '0;
    free_slots    = 0;
    pushed        = 0;
    drops         = 0;

    unique case (r_state)
      StInit, StFlush: begin
        w_we = 1'b1;
        w_wa = r_sweep_idx;
        w_wv = '0;
        if (bus.flushReq) begin
          w_sweep_idx_d = '0;
        end else if (r_sweep_idx == {INDEX_WIDTH{1'b1}}) begin
          w_state_d     = StRun;
          w_sweep_idx_d = '0;
        end else begin
          w_sweep_idx_d = r_sweep_idx + 1'b1;
        end
      end
      StRun: begin
        pop = (r_count != '0);
        if (pop) begin
          w_we     = 1'b1;
          w_wa     = w_head_rec[ENTRY_WIDTH +: INDEX_WIDTH];
          w_wv     = w_head_rec[ENTRY_WIDTH-1:0];
          w_head_d = r_head + 1'b1;
        end else begin
          // Empty FIFO: the lowest surviving lane bypasses straight to the port.
          for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (w_keep[i] && !found) begin
              found     = 1'b1;
              direct[i] = 1'b1;
              w_we      = 1'b1;
              w_wa      = bus.reqIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
              w_wv      = bus.reqEntry[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
          end
        end

        // Capacity counts the slot freed by this cycle's pop.
        free_slots = QUEUE_DEPTH - 32'(r_count) + 32'(pop);
        if (!bus.flushReq) begin
          for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (w_keep[i] && !direct[i]) begin
              if (pushed < free_slots) begin
                w_push_en[i]  = 1'b1;
                w_push_ptr[i] = tail;
                tail          = tail + 1'b1;
                pushed        = pushed + 1;
              end else begin
                drops = drops + 1;
              end
            end
          end
        end
        w_tail_d  = tail;
        w_count_d = CNT_W'(32'(r_count) - 32'(pop) + pushed);
        drop_sum  = {1'b0, r_drop} + 17'(drops);
        w_drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        if (bus.flushReq) begin
          w_state_d     = StFlush;
          w_sweep_idx_d = '0;
          w_head_d      = '0;
          w_tail_d      = '0;
          w_count_d     = '0;
        end
      end
      default: begin
        w_state_d     = StInit;
        w_sweep_idx_d = '0;
      end
    endcase
  end

  // Control state with asynchronous reset back into the post-reset sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StInit;
      r_sweep_idx <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_drop      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sweep_idx <= w_sweep_idx_d;
      r_head      <= w_head_d;
      r_tail      <= w_tail_d;
      r_count     <= w_count_d;
      r_drop      <= w_drop_d;
    end
  end

  // FIFO storage; contents are meaningless outside head..tail so no reset is needed.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (w_push_en[i]) begin
        r_mem[w_push_ptr[i]] <= {bus.reqIndex[i*INDEX_WIDTH +: INDEX_WIDTH],
                                 bus.reqEntry[i*ENTRY_WIDTH +: ENTRY_WIDTH]};
      end
    end
  end

  assign bus.btbWE      = w_we;
  assign bus.btbWA      = w_wa;
  assign bus.btbWV      = w_wv;
  assign bus.busy       = (r_state != StRun);
  assign bus.queueCount = r_count;
  assign bus.dropCount  = r_drop;

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Bench for btb_write_scheduler: directed walk through sweep, bypass, overflow, collision,
// flush and async-reset cases, then random traffic, all checked against a queue-based model.
module tb_btb_write_scheduler;

  localparam int unsigned REQ_NUM     = 2;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned ENTRY_WIDTH = 40;
  localparam int unsigned NUM_IDX     = 1 << INDEX_WIDTH;

  typedef struct {
    logic [INDEX_WIDTH-1:0] idx;
    logic [ENTRY_WIDTH-1:0] ent;
  } rec_t;

  logic clk;
  logic rst_n;

  btb_write_scheduler_if #(
    .REQ_NUM    (REQ_NUM),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .INDEX_WIDTH(INDEX_WIDTH),
    .ENTRY_WIDTH(ENTRY_WIDTH)
  ) bif ();

  btb_write_scheduler #(
    .REQ_NUM    (REQ_NUM),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .INDEX_WIDTH(INDEX_WIDTH),
    .ENTRY_WIDTH(ENTRY_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  bit   m_sweeping;
  int   m_idx;
  rec_t m_fifo[$];
  int   m_drop;

  // Current-cycle stimulus.
  logic [REQ_NUM-1:0]     cur_v;
  logic [INDEX_WIDTH-1:0] cur_idx [REQ_NUM];
  logic [ENTRY_WIDTH-1:0] cur_ent [REQ_NUM];
  logic                   cur_fl;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sweeping = 1'b1;
    m_idx      = 0;
    m_fifo.delete();
    m_drop     = 0;
  endtask

  // Checks this cycle's outputs against the model, then advances the model by one clock.
  task automatic eval_cycle();
    rec_t surv[$];
    rec_t wr;
    bit   has_wr;
    bit   younger;
    check_val("queueCount", 64'(bif.queueCount), 64'(m_fifo.size()));
    check_val("dropCount", 64'(bif.dropCount), 64'(m_drop));
    if (m_sweeping) begin
      check_val("busy_sweep", 64'(bif.busy), 64'd1);
      check_val("we_sweep", 64'(bif.btbWE), 64'd1);
      check_val("wa_sweep", 64'(bif.btbWA), 64'(m_idx));
      check_val("wv_sweep", 64'(bif.btbWV), 64'd0);
      if (cur_fl) m_idx = 0;
      else if (m_idx == NUM_IDX - 1) begin
        m_sweeping = 1'b0;
        m_idx      = 0;
      end else m_idx++;
    end else begin
      check_val("busy_run", 64'(bif.busy), 64'd0);
      for (int i = 0; i < REQ_NUM; i++) begin
        if (cur_v[i]) begin
          younger = 1'b0;
          for (int j = i + 1; j < REQ_NUM; j++)
            if (cur_v[j] && cur_idx[j] == cur_idx[i]) younger = 1'b1;
          if (!younger) surv.push_back('{idx: cur_idx[i], ent: cur_ent[i]});
        end
      end
      has_wr = 1'b0;
      if (m_fifo.size() > 0) begin
        wr = m_fifo.pop_front();
        has_wr = 1'b1;
      end else if (surv.size() > 0) begin
        wr = surv.pop_front();
        has_wr = 1'b1;
      end
      check_val("we_run", 64'(bif.btbWE), 64'(has_wr));
      if (has_wr) begin
        check_val("wa_run", 64'(bif.btbWA), 64'(wr.idx));
        check_val("wv_run", 64'(bif.btbWV), 64'(wr.ent));
      end
      if (cur_fl) begin
        m_fifo.delete();
        m_sweeping = 1'b1;
        m_idx      = 0;
      end else begin
        foreach (surv[k]) begin
          if (m_fifo.size() < QUEUE_DEPTH) m_fifo.push_back(surv[k]);
          else if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [INDEX_WIDTH-1:0] a,
                      input logic [INDEX_WIDTH-1:0] b, input logic fl);
    @(negedge clk);
    cur_v      = v;
    cur_idx[0] = a;
    cur_idx[1] = b;
    cur_ent[0] = {$urandom(), $urandom()};
    cur_ent[1] = {$urandom(), $urandom()};
    cur_fl     = fl;
    bif.reqValid = cur_v;
    bif.reqIndex = {cur_idx[1], cur_idx[0]};
    bif.reqEntry = {cur_ent[1], cur_ent[0]};
    bif.flushReq = cur_fl;
    #1;
    eval_cycle();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_busy", 64'(bif.busy), 64'd1);
    check_val("rst_we", 64'(bif.btbWE), 64'd1);
    check_val("rst_wa", 64'(bif.btbWA), 64'd0);
    check_val("rst_wv", 64'(bif.btbWV), 64'd0);
    check_val("rst_qc", 64'(bif.queueCount), 64'd0);
    check_val("rst_dc", 64'(bif.dropCount), 64'd0);
  endtask

  initial begin
    bif.reqValid = '0;
    bif.reqIndex = '0;
    bif.reqEntry = '0;
    bif.flushReq = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset sweep plus first idle RUN cycle.
    for (int c = 0; c <= NUM_IDX; c++) step(2'b00, 0, 0, 1'b0);

    // Two lanes, empty FIFO: bypass lane0, queue lane1, drain next cycle.
    step(2'b11, 4'd3, 4'd7, 1'b0);
    step(2'b00, 0, 0, 1'b0);

    // Fill to depth, then pop+push at full, then overflow twice.
    step(2'b11, 4'd1, 4'd2, 1'b0);
    step(2'b11, 4'd3, 4'd4, 1'b0);
    step(2'b11, 4'd5, 4'd6, 1'b0);
    step(2'b11, 4'd7, 4'd8, 1'b0);
    step(2'b01, 4'd9, 4'd0, 1'b0);
    step(2'b11, 4'd10, 4'd11, 1'b0);
    step(2'b11, 4'd12, 4'd13, 1'b0);
    for (int c = 0; c < 5; c++) step(2'b00, 0, 0, 1'b0);

    // Same-index collision with empty FIFO: only the younger lane is written.
    step(2'b11, 4'd5, 4'd5, 1'b0);

    // Three queued entries, then flush; second flush mid-sweep at index 9.
    step(2'b11, 4'd1, 4'd2, 1'b0);
    step(2'b11, 4'd3, 4'd4, 1'b0);
    step(2'b11, 4'd6, 4'd8, 1'b0);
    step(2'b00, 0, 0, 1'b1);
    for (int c = 0; c < 9; c++) step(2'b00, 0, 0, 1'b0);
    step(2'b11, 4'd1, 4'd2, 1'b1);
    for (int c = 0; c < 6; c++) step(2'b00, 0, 0, 1'b0);

    // Asynchronous reset mid-sweep at index 6.
    check_val("drop_before_rst", 64'(bif.dropCount), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c <= NUM_IDX; c++) step(2'b00, 0, 0, 1'b0);

    // Random traffic with narrow index range to provoke collisions and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      step(2'($urandom()), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
